sdram_cmd_monitor: RTL and testbench

//  Passive responder-side decoder for the SDRAM command bus driven by the nios/cam arbiter.
//  - Decodes each bus cycle into an SDRAM command.
//  - Shadows the mode register and per-bank open-row state.
//  - Enforces tRCD/tRP spacing and flags protocol violations, e.g. LOAD_MODE issued with banks open.
//  - Sits in parallel with the SDRAM pins; drives nothing onto the bus.

---
 rtl/sdram_cmd_monitor.sv | 205 ++++++++++++++++++++
 tb/tb_sdram_cmd_monitor.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_cmd_monitor.sv
// Passive SDRAM command-bus monitor: decodes commands, shadows mode/bank state, flags tRCD/tRP/state violations.
// Optional refresh-interval checking (violation code 6) is enabled by defining SDRAM_MON_REFRESH_EN.
module sdram_cmd_monitor #(
    parameter int          CHIP     = 0,
    parameter int          TRCD     = 2,
    parameter int          TRP      = 2,
    parameter int          TREFI    = 1560,
    parameter logic [11:0] MODE_RST = 12'h037
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [11:0] SA,
    input  logic [1:0]  BA,
    input  logic [1:0]  CS_N,
    input  logic        CKE,
    input  logic        RAS_N,
    input  logic        CAS_N,
    input  logic        WE_N,
    input  logic [1:0]  DQM,
    output logic        CmdValid,
    output logic [2:0]  CmdCode,
    output logic [11:0] ModeReg,
    output logic [3:0]  BurstLen,
    output logic [1:0]  CasLat,
    output logic [3:0]  BankOpen,
    output logic [47:0] OpenRows,
    output logic        ReadMasked,
    output logic        Violation,
    output logic [2:0]  ViolationCode,
    output logic [15:0] ViolationCount
);

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_ACT   = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_PRE   = 3'd4,
        CMD_BST   = 3'd5,
        CMD_AREF  = 3'd6,
        CMD_LMR   = 3'd7
    } cmd_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_state_t;

    localparam bit SEL  = CHIP[0];
    localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] RCD_LOAD = TW'(TRCD - 1);
    localparam logic [TW-1:0] RP_LOAD  = TW'(TRP - 1);

    logic unused_cs;
    assign unused_cs = CS_N[!SEL];

    cmd_t        cmd;
    logic [2:0]  vcode;
    bank_state_t bank_q [4];
    bank_state_t bank_d [4];
    logic [11:0] row_q  [4];
    logic [11:0] row_d  [4];
    logic [TW-1:0] rcd_q [4];
    logic [TW-1:0] rcd_d [4];
    logic [TW-1:0] rp_q  [4];
    logic [TW-1:0] rp_d  [4];
    logic [11:0] mode_d;

`ifdef SDRAM_MON_REFRESH_EN
    localparam logic [15:0] REFI_LAST = 16'(TREFI - 1);
    logic [15:0] refresh_q, refresh_d;
`else
    localparam int unused_trefi = TREFI;
`endif

    always_comb begin
        cmd = CMD_NONE;
        if (CKE && !CS_N[SEL]) begin
            case ({RAS_N, CAS_N, WE_N})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRE;
                3'b110:  cmd = CMD_BST;
                3'b001:  cmd = CMD_AREF;
                3'b000:  cmd = CMD_LMR;
                default: cmd = CMD_NONE;
            endcase
        end
    end

    always_comb begin
        BankOpen = '0;
        OpenRows = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            BankOpen[b]        = (bank_q[b] == BANK_ACTIVE);
            OpenRows[12*b +: 12] = row_q[b];
        end
    end

    always_comb begin
        case (ModeReg[2:0])
            3'd0:    BurstLen = 4'd1;
            3'd1:    BurstLen = 4'd2;
            3'd2:    BurstLen = 4'd4;
            3'd3:    BurstLen = 4'd8;
            default: BurstLen = 4'd0;
        endcase
        CasLat = ModeReg[5:4];
    end

    always_comb begin
        bank_d = bank_q;
        row_d  = row_q;
        mode_d = ModeReg;
        vcode  = '0;
        for (int unsigned b = 0; b < 4; b++) begin
            rcd_d[b] = (rcd_q[b] != '0) ? rcd_q[b] - 1'b1 : '0;
            rp_d[b]  = (rp_q[b]  != '0) ? rp_q[b]  - 1'b1 : '0;
        end

        case (cmd)
            CMD_ACT: begin
                if (bank_q[BA] == BANK_ACTIVE) vcode = 3'd1;
                else if (rp_q[BA] != '0)       vcode = 3'd4;
                bank_d[BA] = BANK_ACTIVE;
                row_d[BA]  = SA;
                rcd_d[BA]  = RCD_LOAD;
            end
            CMD_READ, CMD_WRITE: begin
                if (bank_q[BA] == BANK_IDLE) vcode = 3'd2;
                else if (rcd_q[BA] != '0)    vcode = 3'd3;
            end
            CMD_PRE: begin
                // Only banks that were actually open restart their precharge timer.
                for (int unsigned b = 0; b < 4; b++) begin
                    if ((SA[10] || BA == 2'(b)) && bank_q[b] == BANK_ACTIVE) begin
                        bank_d[b] = BANK_IDLE;
                        rp_d[b]   = RP_LOAD;
                    end
                end
            end
            CMD_AREF: begin
                if (|BankOpen) vcode = 3'd5;
            end
            CMD_LMR: begin
                if (|BankOpen) vcode = 3'd5;
                mode_d = SA;
            end
            default: ;
        endcase

`ifdef SDRAM_MON_REFRESH_EN
        refresh_d = refresh_q;
        if (cmd == CMD_AREF) begin
            refresh_d = '0;
        end else if (refresh_q == REFI_LAST) begin
            vcode     = 3'd6;
            refresh_d = '0;
        end else if (refresh_q != '1) begin
            refresh_d = refresh_q + 16'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            for (int unsigned b = 0; b < 4; b++) begin
                bank_q[b] <= BANK_IDLE;
                row_q[b]  <= '0;
                rcd_q[b]  <= '0;
                rp_q[b]   <= '0;
            end
            ModeReg        <= MODE_RST;
            CmdValid       <= 1'b0;
            CmdCode        <= '0;
            ReadMasked     <= 1'b0;
            Violation      <= 1'b0;
            ViolationCode  <= '0;
            ViolationCount <= '0;
`ifdef SDRAM_MON_REFRESH_EN
            refresh_q      <= '0;
`endif
        end else begin
            bank_q     <= bank_d;
            row_q      <= row_d;
            rcd_q      <= rcd_d;
            rp_q       <= rp_d;
            ModeReg    <= mode_d;
            CmdValid   <= (cmd != CMD_NONE);
            CmdCode    <= cmd;
            ReadMasked <= (cmd == CMD_READ) && (DQM != 2'b00);
            Violation  <= (vcode != '0);
            if (vcode != '0) begin
                ViolationCode <= vcode;
                if (ViolationCount != '1) ViolationCount <= ViolationCount + 16'd1;
            end
`ifdef SDRAM_MON_REFRESH_EN
            refresh_q  <= refresh_d;
`endif
        end
    end

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
// Self-checking bench for sdram_cmd_monitor: directed vector table, refresh sequence, randomized run vs reference model.
module tb_sdram_cmd_monitor;

    localparam int TRCD  = 2;
    localparam int TRP   = 2;
    localparam int TREFI = 16;

    localparam logic [2:0] R_ACT  = 3'b011;
    localparam logic [2:0] R_RD   = 3'b101;
    localparam logic [2:0] R_WR   = 3'b100;
    localparam logic [2:0] R_PRE  = 3'b010;
    localparam logic [2:0] R_BST  = 3'b110;
    localparam logic [2:0] R_AREF = 3'b001;
    localparam logic [2:0] R_LMR  = 3'b000;
    localparam logic [2:0] R_NOP  = 3'b111;

    logic        clk = 1'b0;
    logic        Reset = 1'b1;
    logic [11:0] SA = '0;
    logic [1:0]  BA = '0;
    logic [1:0]  CS_N = 2'b11;
    logic        CKE = 1'b1;
    logic        RAS_N = 1'b1, CAS_N = 1'b1, WE_N = 1'b1;
    logic [1:0]  DQM = '0;
    logic        CmdValid, ReadMasked, Violation;
    logic [2:0]  CmdCode, ViolationCode;
    logic [11:0] ModeReg;
    logic [3:0]  BurstLen, BankOpen;
    logic [1:0]  CasLat;
    logic [47:0] OpenRows;
    logic [15:0] ViolationCount;

    sdram_cmd_monitor #(.CHIP(0), .TRCD(TRCD), .TRP(TRP), .TREFI(TREFI), .MODE_RST(12'h037)) dut (
        .clk(clk), .Reset(Reset), .SA(SA), .BA(BA), .CS_N(CS_N), .CKE(CKE),
        .RAS_N(RAS_N), .CAS_N(CAS_N), .WE_N(WE_N), .DQM(DQM),
        .CmdValid(CmdValid), .CmdCode(CmdCode), .ModeReg(ModeReg), .BurstLen(BurstLen),
        .CasLat(CasLat), .BankOpen(BankOpen), .OpenRows(OpenRows), .ReadMasked(ReadMasked),
        .Violation(Violation), .ViolationCode(ViolationCode), .ViolationCount(ViolationCount)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: bank timing judged from cycle stamps of the last ACT/PRE per bank.
    int          m_cyc = 0;
    bit          m_open [4];
    logic [11:0] m_row  [4];
    int          m_act  [4];
    int          m_pre  [4];
    logic [11:0] m_mode;
    int          m_cnt;
    logic [2:0]  m_vheld;
    int          m_refa;
    logic [2:0]  e_code;
    logic        e_viol, e_rm;

    task automatic model_step(input logic rst, input logic cke, input logic [1:0] cs,
                              input logic [2:0] rcw, input logic [1:0] ba,
                              input logic [11:0] sa, input logic [1:0] dqm);
        logic [2:0] code, c;
        bit any;
        m_cyc++;
        e_code = 0; e_viol = 0; e_rm = 0;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                m_open[i] = 0; m_row[i] = '0; m_act[i] = -1000; m_pre[i] = -1000;
            end
            m_mode = 12'h037; m_cnt = 0; m_vheld = 0; m_refa = m_cyc;
            return;
        end
        code = 0; c = 0;
        any = m_open[0] | m_open[1] | m_open[2] | m_open[3];
        if (cke && !cs[0]) begin
            case (rcw)
                R_ACT:  code = 1;
                R_RD:   code = 2;
                R_WR:   code = 3;
                R_PRE:  code = 4;
                R_BST:  code = 5;
                R_AREF: code = 6;
                R_LMR:  code = 7;
                default: code = 0;
            endcase
        end
        case (code)
            1: begin
                if (m_open[ba]) c = 1;
                else if (m_cyc - m_pre[ba] < TRP) c = 4;
                m_open[ba] = 1; m_row[ba] = sa; m_act[ba] = m_cyc;
            end
            2, 3: begin
                if (!m_open[ba]) c = 2;
                else if (m_cyc - m_act[ba] < TRCD) c = 3;
            end
            4: for (int i = 0; i < 4; i++)
                   if ((sa[10] || i == int'(ba)) && m_open[i]) begin
                       m_open[i] = 0; m_pre[i] = m_cyc;
                   end
            6: begin
                if (any) c = 5;
                m_refa = m_cyc;
            end
            7: begin
                if (any) c = 5;
                m_mode = sa;
            end
            default: ;
        endcase
`ifdef SDRAM_MON_REFRESH_EN
        if (code != 6 && m_cyc - m_refa == TREFI) begin
            c = 6; m_refa = m_cyc;
        end
`endif
        e_code = code;
        e_viol = (c != 0);
        e_rm   = (code == 2) && (dqm != 2'b00);
        if (c != 0) begin
            m_vheld = c;
            if (m_cnt < 65535) m_cnt++;
        end
    endtask

    function automatic logic [3:0] exp_bl(input logic [11:0] mode);
        case (mode[2:0])
            3'd0: return 4'd1;
            3'd1: return 4'd2;
            3'd2: return 4'd4;
            3'd3: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [47:0] row_mask(input logic [3:0] bo);
        logic [47:0] m;
        m = '0;
        for (int i = 0; i < 4; i++) if (bo[i]) m[12*i +: 12] = 12'hFFF;
        return m;
    endfunction

    task automatic drive(input logic rst, input logic cke, input logic [1:0] cs,
                         input logic [2:0] rcw, input logic [1:0] ba,
                         input logic [11:0] sa, input logic [1:0] dqm);
        Reset = rst; CKE = cke; CS_N = cs; {RAS_N, CAS_N, WE_N} = rcw;
        BA = ba; SA = sa; DQM = dqm;
        model_step(rst, cke, cs, rcw, ba, sa, dqm);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int n);
        logic [3:0] bo;
        bo = {m_open[3], m_open[2], m_open[1], m_open[0]};
        chk($sformatf("rnd%0d CmdValid", n), CmdValid, e_code != 0);
        chk($sformatf("rnd%0d CmdCode", n), CmdCode, e_code);
        chk($sformatf("rnd%0d Violation", n), Violation, e_viol);
        chk($sformatf("rnd%0d ViolationCode", n), ViolationCode, m_vheld);
        chk($sformatf("rnd%0d ViolationCount", n), ViolationCount, 16'(m_cnt));
        chk($sformatf("rnd%0d BankOpen", n), BankOpen, bo);
        chk($sformatf("rnd%0d OpenRows", n), OpenRows & row_mask(bo),
            {m_row[3], m_row[2], m_row[1], m_row[0]} & row_mask(bo));
        chk($sformatf("rnd%0d ModeReg", n), ModeReg, m_mode);
        chk($sformatf("rnd%0d BurstLen", n), BurstLen, exp_bl(m_mode));
        chk($sformatf("rnd%0d CasLat", n), CasLat, m_mode[5:4]);
        chk($sformatf("rnd%0d ReadMasked", n), ReadMasked, e_rm);
    endtask

    typedef struct {
        logic        rst;
        logic        cke;
        logic [1:0]  cs_n;
        logic [2:0]  rcw;
        logic [1:0]  ba;
        logic [11:0] sa;
        logic [1:0]  dqm;
        logic [2:0]  code;
        logic        viol;
        logic [2:0]  vcode;
        logic [15:0] vcnt;
        logic [3:0]  bo;
        logic [47:0] rows;
        logic [11:0] mode;
        logic [3:0]  bl;
        logic [1:0]  cl;
        logic        rm;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic rst, input logic cke, input logic [1:0] cs_n,
                                input logic [2:0] rcw, input logic [1:0] ba, input logic [11:0] sa,
                                input logic [1:0] dqm, input logic [2:0] code, input logic viol,
                                input logic [2:0] vcode, input logic [15:0] vcnt, input logic [3:0] bo,
                                input logic [47:0] rows, input logic [11:0] mode, input logic [3:0] bl,
                                input logic [1:0] cl, input logic rm);
        vec_t v;
        v.rst = rst; v.cke = cke; v.cs_n = cs_n; v.rcw = rcw; v.ba = ba; v.sa = sa; v.dqm = dqm;
        v.code = code; v.viol = viol; v.vcode = vcode; v.vcnt = vcnt; v.bo = bo; v.rows = rows;
        v.mode = mode; v.bl = bl; v.cl = cl; v.rm = rm;
        return v;
    endfunction

    initial begin
        //            rst cke cs     rcw     ba  sa      dqm   code v vc cnt bo       rows                mode     bl cl rm
        tv.push_back(mk(1, 1, 2'b10, R_NOP,  0, 12'h000, 2'b00, 0, 0, 0, 0, 4'b0000, 48'h0,             12'h037, 0, 3, 0));
        tv.push_back(mk(1, 1, 2'b10, R_NOP,  0, 12'h000, 2'b00, 0, 0, 0, 0, 4'b0000, 48'h0,             12'h037, 0, 3, 0));
        tv.push_back(mk(0, 1, 2'b10, R_LMR,  0, 12'h022, 2'b00, 7, 0, 0, 0, 4'b0000, 48'h0,             12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  1, 12'h0A5, 2'b00, 1, 0, 0, 0, 4'b0010, 48'h0000000A5000,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_NOP,  0, 12'h000, 2'b00, 0, 0, 0, 0, 4'b0010, 48'h0000000A5000,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_RD,   1, 12'h000, 2'b00, 2, 0, 0, 0, 4'b0010, 48'h0000000A5000,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  0, 12'h111, 2'b00, 1, 0, 0, 0, 4'b0011, 48'h0000000A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_RD,   0, 12'h000, 2'b00, 2, 1, 3, 1, 4'b0011, 48'h0000000A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_RD,   0, 12'h000, 2'b00, 2, 0, 3, 1, 4'b0011, 48'h0000000A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  2, 12'h222, 2'b00, 1, 0, 3, 1, 4'b0111, 48'h0002220A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_PRE,  0, 12'h400, 2'b00, 4, 0, 3, 1, 4'b0000, 48'h0,             12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  2, 12'h2B2, 2'b00, 1, 1, 4, 2, 4'b0100, 48'h0002B20A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_NOP,  0, 12'h000, 2'b00, 0, 0, 4, 2, 4'b0100, 48'h0002B20A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  3, 12'h333, 2'b00, 1, 0, 4, 2, 4'b1100, 48'h3332B20A5111,  12'h022, 4, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_LMR,  0, 12'h023, 2'b00, 7, 1, 5, 3, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_WR,   1, 12'h000, 2'b11, 3, 1, 2, 4, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 0, 2'b10, R_ACT,  0, 12'hFFF, 2'b00, 0, 0, 2, 4, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b01, R_ACT,  0, 12'hFFF, 2'b00, 0, 0, 2, 4, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_PRE,  0, 12'h000, 2'b00, 4, 0, 2, 4, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_BST,  0, 12'h000, 2'b00, 5, 0, 2, 4, 4'b1100, 48'h3332B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_ACT,  3, 12'h3C3, 2'b00, 1, 1, 1, 5, 4'b1100, 48'h3C32B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(0, 1, 2'b10, R_RD,   2, 12'h000, 2'b01, 2, 0, 1, 5, 4'b1100, 48'h3C32B20A5111,  12'h023, 8, 2, 1));
        tv.push_back(mk(0, 1, 2'b10, R_AREF, 0, 12'h000, 2'b00, 6, 1, 5, 6, 4'b1100, 48'h3C32B20A5111,  12'h023, 8, 2, 0));
        tv.push_back(mk(1, 1, 2'b10, R_ACT,  1, 12'h555, 2'b00, 0, 0, 0, 0, 4'b0000, 48'h0,             12'h037, 0, 3, 0));

        #1;
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].rst, tv[i].cke, tv[i].cs_n, tv[i].rcw, tv[i].ba, tv[i].sa, tv[i].dqm);
            chk($sformatf("vec%0d CmdValid", i), CmdValid, tv[i].code != 0);
            chk($sformatf("vec%0d CmdCode", i), CmdCode, tv[i].code);
            chk($sformatf("vec%0d Violation", i), Violation, tv[i].viol);
            chk($sformatf("vec%0d ViolationCode", i), ViolationCode, tv[i].vcode);
            chk($sformatf("vec%0d ViolationCount", i), ViolationCount, tv[i].vcnt);
            chk($sformatf("vec%0d BankOpen", i), BankOpen, tv[i].bo);
            chk($sformatf("vec%0d OpenRows", i), OpenRows & row_mask(tv[i].bo), tv[i].rows & row_mask(tv[i].bo));
            chk($sformatf("vec%0d ModeReg", i), ModeReg, tv[i].mode);
            chk($sformatf("vec%0d BurstLen", i), BurstLen, tv[i].bl);
            chk($sformatf("vec%0d CasLat", i), CasLat, tv[i].cl);
            chk($sformatf("vec%0d ReadMasked", i), ReadMasked, tv[i].rm);
        end

        // Refresh interval: AREF then TREFI idle cycles; only the last may flag code 6.
        drive(1, 1, 2'b10, R_NOP, 0, 12'h000, 2'b00);
        drive(0, 1, 2'b10, R_AREF, 0, 12'h000, 2'b00);
        chk("refresh AREF idle", Violation, 1'b0);
        for (int i = 0; i < TREFI; i++) begin
            drive(0, 1, 2'b10, R_NOP, 0, 12'h000, 2'b00);
`ifdef SDRAM_MON_REFRESH_EN
            chk($sformatf("refresh idle%0d Violation", i), Violation, i == TREFI - 1);
            if (i == TREFI - 1) chk("refresh code", ViolationCode, 3'd6);
`else
            chk($sformatf("refresh idle%0d Violation", i), Violation, 1'b0);
`endif
        end

        // TRCD boundary with a gap of exactly TRCD cycles after a fresh reset.
        drive(1, 1, 2'b10, R_NOP, 0, 12'h000, 2'b00);
        drive(0, 1, 2'b10, R_ACT, 2, 12'h0F0, 2'b00);
        drive(0, 1, 2'b10, R_NOP, 0, 12'h000, 2'b00);
        drive(0, 1, 2'b10, R_WR,  2, 12'h000, 2'b00);
        chk("trcd boundary Violation", Violation, 1'b0);
        drive(0, 1, 2'b10, R_PRE, 2, 12'h000, 2'b00);
        drive(0, 1, 2'b10, R_NOP, 0, 12'h000, 2'b00);
        drive(0, 1, 2'b10, R_ACT, 2, 12'h0F1, 2'b00);
        chk("trp boundary Violation", Violation, 1'b0);
        chk("trp boundary OpenRows", OpenRows[35:24], 12'h0F1);

        for (int n = 0; n < 3000; n++) begin
            logic rst, cke;
            logic [1:0] cs;
            rst = ($urandom_range(0, 299) == 0);
            cke = ($urandom_range(0, 15) != 0);
            cs  = {1'($urandom), 1'($urandom_range(0, 4) == 0)};
            drive(rst, cke, cs, 3'($urandom), 2'($urandom), 12'($urandom), 2'($urandom));
            check_model(n);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
